// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// MEM-stage memory access controller for the 16-bit pipelined CPU.
// Runs the SRAM port, which is shared with instruction fetch, through a
// multi-cycle read or write for the load/store held in EX/MEM. While a data
// access is in flight, fetch is starved and the pipeline is frozen with
// mem_stall. The registered load result is mem_read_data.
//
// Optional feature: define UART_MMIO_EN to map the UART at 0xBF00/0xBF01.
// Without it, every address goes to SRAM and the UART outputs are tied low.
//
// Ports:
//   clk, rst (async, active-low)
//   emo_mem_op/emo_alu_answer/emo_mem_wdata : request from EX/MEM
//   mem_read_data, mem_stall                : load result, pipeline freeze
//   if_addr, if_inst, if_inst_valid         : fetch side of the shared port
//   ram_*                                   : SRAM pins
//   uart_*                                  : UART MMIO strobes and data
//   dbg_state                               : current FSM state
//
// Handshake: a request (emo_mem_op 01/10) is accepted in IDLE in the same
// cycle it appears. EX/MEM holds it steady for as long as mem_stall is high.
// In DONE, mem_stall drops and the pipeline advances, which retires the
// request. if_inst is usable only in a cycle where if_inst_valid is high.
module mem_access_ctrl #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  emo_mem_op,
  input  logic [15:0] emo_alu_answer,
  input  logic [15:0] emo_mem_wdata,
  output logic [15:0] mem_read_data,
  output logic        mem_stall,
  input  logic [15:0] if_addr,
  output logic [15:0] if_inst,
  output logic        if_inst_valid,
  output logic [17:0] ram_addr,
  output logic [15:0] ram_data_out,
  input  logic [15:0] ram_data_in,
  output logic        ram_data_oe,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_ready,
  input  logic        uart_tx_ready,
  output logic        uart_rx_ack,
  output logic        uart_tx_strobe,
  output logic [7:0]  uart_tx_data,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    RD_LATCH = 3'd2,
    WR_PULSE = 3'd3,
    WR_HOLD  = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam logic [2:0] WC = 3'(WAIT_CYCLES);

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic        is_rd, is_wr, req, is_uart;
  logic        rd_load;
  logic [15:0] rd_value;

  assign is_rd = (emo_mem_op == 2'b01);
  assign is_wr = (emo_mem_op == 2'b10);
  assign req   = is_rd | is_wr;

`ifdef UART_MMIO_EN
  // 0xBF00 and 0xBF01 share every address bit except bit 0.
  assign is_uart = (emo_alu_answer[15:1] == 15'h5F80);
`else
  assign is_uart = 1'b0;
  logic unused_uart;
  assign unused_uart = ^{uart_rx_data, uart_rx_ready, uart_tx_ready};
`endif

  assign if_inst   = ram_data_in;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= 3'd0;
      mem_read_data <= 16'h0000;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (rd_load) mem_read_data <= rd_value;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    ram_addr       = 18'h0;
    ram_data_out   = 16'h0;
    ram_data_oe    = 1'b0;
    ram_oe_n       = 1'b1;
    ram_we_n       = 1'b1;
    if_inst_valid  = 1'b0;
    mem_stall      = 1'b0;
    rd_load        = 1'b0;
    rd_value       = ram_data_in;
    uart_rx_ack    = 1'b0;
    uart_tx_strobe = 1'b0;
    uart_tx_data   = 8'h00;

    case (state)
      IDLE: begin
        if (!req) begin
          ram_addr      = {2'b00, if_addr};
          ram_oe_n      = 1'b0;
          if_inst_valid = 1'b1;
        end else if (is_uart) begin
          // UART access completes in the accept cycle; SRAM stays idle.
          mem_stall = 1'b1;
          state_nxt = DONE;
`ifdef UART_MMIO_EN
          if (is_rd) begin
            rd_load     = 1'b1;
            rd_value    = emo_alu_answer[0] ? {14'b0, uart_rx_ready, uart_tx_ready}
                                            : {8'b0, uart_rx_data};
            uart_rx_ack = ~emo_alu_answer[0];
          end else if (!emo_alu_answer[0]) begin
            uart_tx_strobe = 1'b1;
            uart_tx_data   = emo_mem_wdata[7:0];
          end
`endif
        end else if (is_rd) begin
          ram_addr  = {2'b00, emo_alu_answer};
          ram_oe_n  = 1'b0;
          mem_stall = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_nxt = RD_LATCH;
          end else begin
            state_nxt = RD_WAIT;
            cnt_nxt   = WC - 3'd1;
          end
        end else begin
          // Write setup: bus driven, both strobes inactive.
          ram_addr     = {2'b00, emo_alu_answer};
          ram_data_out = emo_mem_wdata;
          ram_data_oe  = 1'b1;
          mem_stall    = 1'b1;
          state_nxt    = WR_PULSE;
          cnt_nxt      = WC;
        end
      end
      RD_WAIT: begin
        ram_addr  = {2'b00, emo_alu_answer};
        ram_oe_n  = 1'b0;
        mem_stall = 1'b1;
        if (cnt == 3'd0) state_nxt = RD_LATCH;
        else             cnt_nxt   = cnt - 3'd1;
      end
      RD_LATCH: begin
        ram_addr  = {2'b00, emo_alu_answer};
        ram_oe_n  = 1'b0;
        mem_stall = 1'b1;
        rd_load   = 1'b1;
        state_nxt = DONE;
      end
      WR_PULSE: begin
        ram_addr     = {2'b00, emo_alu_answer};
        ram_data_out = emo_mem_wdata;
        ram_data_oe  = 1'b1;
        ram_we_n     = 1'b0;
        mem_stall    = 1'b1;
        if (cnt == 3'd0) state_nxt = WR_HOLD;
        else             cnt_nxt   = cnt - 3'd1;
      end
      WR_HOLD: begin
        // Data is held one cycle past the rising edge of we_n.
        ram_addr     = {2'b00, emo_alu_answer};
        ram_data_out = emo_mem_wdata;
        ram_data_oe  = 1'b1;
        mem_stall    = 1'b1;
        state_nxt    = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // While rst is low, the pins are forced safe. This also ends a write
    // pulse at once, with no clock edge needed.
    if (!rst) begin
      mem_stall      = 1'b0;
      if_inst_valid  = 1'b0;
      ram_we_n       = 1'b1;
      ram_oe_n       = 1'b1;
      ram_data_oe    = 1'b0;
      ram_addr       = 18'h0;
      uart_rx_ack    = 1'b0;
      uart_tx_strobe = 1'b0;
    end
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

MEM-stage memory access controller for the 16-bit pipelined CPU. Takes the load/store request held in the EX/MEM latch, runs the shared SRAM through a multi-cycle read or write sequence, and produces the load result that the MEM/WB latch captures. The forwarding unit later sees that result as `mwo_ram_read_answer`. The SRAM port is shared with instruction fetch. While a data access runs, fetch is starved and the pipeline is frozen through `mem_stall`.

## Interface
Parameters:
- `WAIT_CYCLES`, default 1: extra SRAM wait cycles per access, legal range 0–7.

Ports:
- `clk`, input, 1: system clock.
- `rst`, input, 1: reset, asynchronous, active-low.
- `emo_mem_op`, input, 2: request from EX/MEM. 00 = none, 01 = read, 10 = write, 11 = treated as none.
- `emo_alu_answer`, input, 16: effective address.
- `emo_mem_wdata`, input, 16: store data.
- `mem_read_data`, output, 16: registered load result.
- `mem_stall`, output, 1: freeze PC, IF/ID, ID/EX and EX/MEM.
- `if_addr`, input, 16: fetch address from IF.
- `if_inst`, output, 16: fetched instruction.
- `if_inst_valid`, output, 1: `if_inst` is valid this cycle.
- `ram_addr`, output, 18: SRAM address, formed as {2'b00, addr}.
- `ram_data_out`, output, 16: SRAM write data.
- `ram_data_in`, input, 16: SRAM read data.
- `ram_data_oe`, output, 1: tristate enable for the SRAM data bus.
- `ram_oe_n`, output, 1: SRAM output enable, active-low.
- `ram_we_n`, output, 1: SRAM write enable, active-low.
- `uart_rx_data`, input, 8: UART receive data.
- `uart_rx_ready`, input, 1: UART has received a byte.
- `uart_tx_ready`, input, 1: UART can accept a byte.
- `uart_rx_ack`, output, 1: one-cycle pulse acknowledging a receive read.
- `uart_tx_strobe`, output, 1: one-cycle pulse issuing a transmit byte.
- `uart_tx_data`, output, 8: transmit byte.

## Operation
- FSM states: IDLE, RD_WAIT, RD_LATCH, WR_PULSE, WR_HOLD, DONE.
- IDLE with no request:
  - SRAM serves fetch: `ram_addr`={2'b00,`if_addr`}, `ram_oe_n`=0, `ram_we_n`=1, `ram_data_oe`=0.
  - `if_inst`=`ram_data_in`, `if_inst_valid`=1, `mem_stall`=0.
- IDLE with a read request:
  - Drive `ram_addr`=`emo_alu_answer`, `ram_oe_n`=0, `mem_stall`=1, `if_inst_valid`=0.
  - Next state is RD_WAIT, or RD_LATCH if `WAIT_CYCLES`=0.
- RD_WAIT:
  - Lasts `WAIT_CYCLES` cycles.
  - Address and `ram_oe_n` held; `mem_stall`=1.
- RD_LATCH: `mem_read_data`<=`ram_data_in` at the clock edge; `mem_stall`=1; next state DONE.
- IDLE with a write request:
  - Drive `ram_addr`, `ram_data_out`=`emo_mem_wdata`, `ram_data_oe`=1, `ram_oe_n`=1, `ram_we_n`=1, `mem_stall`=1.
  - Next state WR_PULSE.
- WR_PULSE:
  - Lasts `WAIT_CYCLES`+1 cycles with `ram_we_n`=0.
  - Address and data held; `mem_stall`=1.
- WR_HOLD: `ram_we_n`=1, data still driven, `mem_stall`=1; next state DONE.
- DONE:
  - `mem_stall`=0, `if_inst_valid`=0, SRAM idle.
  - Always returns to IDLE.
  - The pipeline advances at this edge, so the old request is never re-issued.
- EX/MEM is frozen only by `mem_stall` while an access is in progress. The request inputs stay stable from the IDLE-accept cycle through DONE.
- A cycle-0 grant to data over fetch is absolute. Fetch has no priority.
- `ram_data_oe` and `ram_oe_n` are never both active.

## Timing
- Read: `WAIT_CYCLES`+2 stall cycles, with data valid in DONE. With the default `WAIT_CYCLES`=1 this is 3 stall cycles.
- Write: `WAIT_CYCLES`+3 stall cycles. With the default this is 4 stall cycles.
- `mem_stall` is combinational: (IDLE && request) || state ∉ {IDLE, DONE}.
- Reset values:
  - State is IDLE and `mem_read_data`=0.
  - While `rst`=0 the outputs are forced to: `mem_stall`=0, `if_inst_valid`=0, `ram_we_n`=1, `ram_oe_n`=1, `ram_data_oe`=0, `ram_addr`=0, UART pulses 0.
- Reset mid-write: `ram_we_n` returns to 1 asynchronously and the write is abandoned. There is no retry.
- `WAIT_CYCLES` counter: 3 bits, loaded on state entry, counting down to 0. It never wraps.

## Configuration
`UART_MMIO_EN` defined:
- Address 0xBF00 read returns {8'b0,`uart_rx_data`} and pulses `uart_rx_ack`.
- Address 0xBF00 write pulses `uart_tx_strobe` with `uart_tx_data`=`emo_mem_wdata[7:0]`.
- Address 0xBF01 read returns {14'b0,`uart_rx_ready`,`uart_tx_ready`}.
- A write to 0xBF01 is ignored.
- UART accesses go IDLE→DONE with one stall cycle. SRAM is untouched and fetch gets no grant.
- The UART pulse fires in the IDLE-accept cycle, and `mem_read_data` is captured at the same edge.

`UART_MMIO_EN` undefined: every address maps to SRAM, and the UART outputs are tied to 0.

## Test plan
- Reset release with no request and `if_addr`=0x0004, `ram_data_in`=0x4A21 → `if_inst`=0x4A21, `if_inst_valid`=1, `mem_stall`=0.
- Read of 0x0100 with `ram_data_in`=0xBEEF, `WAIT_CYCLES`=1 → `mem_stall` high 3 cycles, `mem_read_data`=0xBEEF in DONE, `ram_we_n` stays 1.
- Write of 0x1234 to 0x0200, `WAIT_CYCLES`=1 → `ram_we_n` low exactly 2 cycles, `ram_data_oe` high 4 cycles, `mem_stall` high 4 cycles.
- Back-to-back read then write: the second access starts in the IDLE cycle after DONE, and exactly one `mem_stall`=0 gap is observed.
- `rst` dropped in the first WR_PULSE cycle → `ram_we_n`=1 immediately; after release, state is IDLE and fetch resumes.
- With `UART_MMIO_EN`, read 0xBF01 with rx_ready=1, tx_ready=0 → `mem_read_data`=0x0002 and 1 stall cycle. Write 0x0041 to 0xBF00 → a single `uart_tx_strobe` with `uart_tx_data`=0x41.
